wishbone_arbiter: RTL

Round-robin Wishbone classic bus arbiter. It shares the single DM slave port (wishbone_dm_slave) between NUM_MASTERS masters: the JTAG-TAP-driven wishbone_master, a future CPU/debug-ROM master, and so on. It grants one master per bus tenure, muxes that master's request onto the slave and routes the ack back to it. A watchdog terminates stalled cycles with an error so that a hung slave cannot lock up the JTAG path.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wishbone_arbiter_rr_select.sv | 26 ++
 rtl/wishbone_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone round-robin arbiter.
// It holds the FSM state encoding and the default bus geometry.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam int DEFAULT_ADDR_W         = 32;
    localparam int DEFAULT_DATA_W         = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Returns (base + step) reduced modulo n. Both inputs are non-negative.
    function automatic int wrap_index(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/wishbone_arbiter_rr_select.sv
// Combinational round-robin picker. It returns the one-hot grant for the
// first requester found after last_grant, wrapping around the master ring.
module rr_select
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [NUM_MASTERS-1:0] grant_next
);

    // Scan from the farthest candidate to the nearest one. The last hit
    // written is therefore the highest-priority requester.
    always_comb begin
        grant_next = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (req[IDX_W'(wrap_index(int'(last_grant), k, NUM_MASTERS))]) begin
                grant_next = '0;
                grant_next[IDX_W'(wrap_index(int'(last_grant), k, NUM_MASTERS))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone classic arbiter that shares one slave between several
// masters. A watchdog aborts cycles whose slave never acknowledges.
module wishbone_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
    output logic [DATA_W-1:0]             m_data_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_data_o,
    input  logic [DATA_W-1:0]             s_data_i,
    input  logic                          s_ack_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = WATCHDOG_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

    state_t                 state_q, state_n;
    logic [NUM_MASTERS-1:0] grant_q, grant_n;
    logic [IDX_W-1:0]       gidx_q, gidx_n;
    logic [IDX_W-1:0]       last_q, last_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;

    logic [NUM_MASTERS-1:0] sel_grant;
    logic [IDX_W-1:0]       sel_idx;

    logic                   cyc_sel;
    logic                   stb_sel;
    logic                   we_sel;
    logic [ADDR_W-1:0]      addr_sel;
    logic [DATA_W-1:0]      data_sel;
    logic                   timeout_hit;

    rr_select #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_rr_select (
        .req       (m_cyc_i),
        .last_grant(last_q),
        .grant_next(sel_grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel_grant[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign cyc_sel  = m_cyc_i[gidx_q];
    assign stb_sel  = m_stb_i[gidx_q];
    assign we_sel   = m_we_i[gidx_q];
    assign addr_sel = m_addr_i[int'(gidx_q)*ADDR_W +: ADDR_W];
    assign data_sel = m_data_i[int'(gidx_q)*DATA_W +: DATA_W];

    // An ack arriving on the threshold cycle wins, so it blocks the timeout.
    assign timeout_hit = WATCHDOG_ON && (state_q == GRANT) && cyc_sel && stb_sel &&
                         !s_ack_i && (cnt_q == CNT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            gidx_q  <= gidx_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        gidx_n  = gidx_q;
        last_n  = last_q;
        cnt_n   = '0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    grant_n = sel_grant;
                    gidx_n  = sel_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!cyc_sel) begin
                    grant_n = '0;
                    last_n  = gidx_q;
                    state_n = IDLE;
                end else if (timeout_hit) begin
                    state_n = ABORT;
                end else if (!s_ack_i && stb_sel && (cnt_q != CNT_MAX)) begin
                    cnt_n = cnt_q + 1'b1;
                end else if (!s_ack_i && stb_sel) begin
                    cnt_n = cnt_q;
                end
            end
            ABORT: begin
                if (!cyc_sel) begin
                    grant_n = '0;
                    last_n  = gidx_q;
                    state_n = IDLE;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Only the granted master is ever connected to the slave, and only while
    // the tenure is live. ABORT keeps the slave isolated until the master lets go.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        if (state_q == GRANT) begin
            s_cyc_o          = cyc_sel & ~timeout_hit;
            s_stb_o          = stb_sel & ~timeout_hit;
            s_we_o           = we_sel;
            s_addr_o         = addr_sel;
            s_data_o         = data_sel;
            m_ack_o[gidx_q]  = s_ack_i;
            m_err_o[gidx_q]  = timeout_hit;
        end
    end

    assign m_data_o = s_data_i;
    assign grant_o  = grant_q;
    assign busy_o   = (state_q != IDLE);

endmodule
